// File: rtl/n101_icache_pkg.sv
// Shared types and helpers for the n101 instruction-cache RAM controller.
package n101_icache_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LS   = 2'd2,
    ST_WAKE = 2'd3
  } ctrl_state_e;

  // Never returns less than 1 so counters always keep at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/n101_icache_ram_ctrl.sv
// Instruction-cache RAM controller: zero-fill sweep, refill/fetch arbitration, sleep control.
// Optional light-sleep entry after idle cycles is enabled by `define N101_ICACHE_RAM_LS_EN.
module n101_icache_ram_ctrl
  import n101_icache_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MW          = 4,
  parameter int DP          = 32,
  parameter int LS_IDLE_CYC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifu_req_vld,
  output logic          ifu_req_rdy,
  input  logic [AW-1:0] ifu_req_addr,
  output logic          ifu_rsp_vld,
  output logic [DW-1:0] ifu_rsp_dat,
  input  logic          rfl_req_vld,
  output logic          rfl_req_rdy,
  input  logic [AW-1:0] rfl_req_addr,
  input  logic [MW-1:0] rfl_req_wem,
  input  logic [DW-1:0] rfl_req_dat,
  input  logic          inv_req,
  output logic          init_done,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ls,
  output logic          ram_ds,
  output logic          ram_sd
);

  localparam int CW = clog2(DP);
  localparam logic [CW-1:0] SWEEP_LAST = CW'(DP - 1);

  if (DP < 2 || LS_IDLE_CYC < 1) begin : g_cfg_check
    $error("n101_icache_ram_ctrl: DP must be >= 2 and LS_IDLE_CYC >= 1");
  end

  ctrl_state_e   state;
  logic [CW-1:0] sweep_cnt;

  assign ram_ds      = 1'b0;
  assign ram_sd      = 1'b0;
  assign ifu_rsp_dat = ram_dout;

  // Accepted requests steer the RAM in the same cycle; INIT owns the port.
  always_comb begin
    rfl_req_rdy = 1'b0;
    ifu_req_rdy = 1'b0;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wem     = '0;
    ram_din     = '0;
    case (state)
      ST_INIT: begin
        ram_cs   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = AW'(sweep_cnt);
        ram_wem  = '1;
      end
      ST_RUN: begin
        if (!inv_req) begin
          rfl_req_rdy = rfl_req_vld;
          ifu_req_rdy = ~rfl_req_vld;
          if (rfl_req_vld) begin
            ram_cs   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = rfl_req_addr;
            ram_wem  = rfl_req_wem;
            ram_din  = rfl_req_dat;
          end else if (ifu_req_vld) begin
            ram_cs   = 1'b1;
            ram_addr = ifu_req_addr;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef N101_ICACHE_RAM_LS_EN
  localparam int IW = clog2(LS_IDLE_CYC + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(LS_IDLE_CYC);

  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_nxt;

  always_comb begin
    idle_nxt = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;
  end
`else
  assign ram_ls = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      sweep_cnt   <= '0;
      init_done   <= 1'b0;
      ifu_rsp_vld <= 1'b0;
`ifdef N101_ICACHE_RAM_LS_EN
      idle_cnt    <= '0;
      ram_ls      <= 1'b0;
`endif
    end else begin
      ifu_rsp_vld <= ifu_req_vld & ifu_req_rdy;
      if (inv_req) begin
        state     <= ST_INIT;
        sweep_cnt <= '0;
        init_done <= 1'b0;
`ifdef N101_ICACHE_RAM_LS_EN
        idle_cnt  <= '0;
        ram_ls    <= 1'b0;
`endif
      end else begin
        case (state)
          ST_INIT: begin
            if (sweep_cnt == SWEEP_LAST) begin
              state     <= ST_RUN;
              sweep_cnt <= '0;
              init_done <= 1'b1;
            end else begin
              sweep_cnt <= sweep_cnt + 1'b1;
            end
          end
          ST_RUN: begin
`ifdef N101_ICACHE_RAM_LS_EN
            if (ram_cs) begin
              idle_cnt <= '0;
            end else if (idle_nxt == IDLE_MAX) begin
              state    <= ST_LS;
              ram_ls   <= 1'b1;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_nxt;
            end
`endif
          end
`ifdef N101_ICACHE_RAM_LS_EN
          ST_LS: begin
            if (ifu_req_vld || rfl_req_vld) begin
              state  <= ST_WAKE;
              ram_ls <= 1'b0;
            end
          end
          ST_WAKE: state <= ST_RUN;
`endif
          default: state <= ST_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_n101_icache_ram_ctrl.sv
// Self-checking bench for n101_icache_ram_ctrl (DP=32) with a behavioural RAM and memory model.
module tb_n101_icache_ram_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int DP = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ifu_req_vld, ifu_req_rdy;
  logic [AW-1:0] ifu_req_addr;
  logic          ifu_rsp_vld;
  logic [DW-1:0] ifu_rsp_dat;
  logic          rfl_req_vld, rfl_req_rdy;
  logic [AW-1:0] rfl_req_addr;
  logic [MW-1:0] rfl_req_wem;
  logic [DW-1:0] rfl_req_dat;
  logic          inv_req, init_done;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_ls, ram_ds, ram_sd;

  int checks = 0;
  int errors = 0;

  n101_icache_ram_ctrl #(.AW(AW), .DW(DW), .MW(MW), .DP(DP), .LS_IDLE_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_vld(ifu_req_vld), .ifu_req_rdy(ifu_req_rdy), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_vld(ifu_rsp_vld), .ifu_rsp_dat(ifu_rsp_dat),
    .rfl_req_vld(rfl_req_vld), .rfl_req_rdy(rfl_req_rdy), .rfl_req_addr(rfl_req_addr),
    .rfl_req_wem(rfl_req_wem), .rfl_req_dat(rfl_req_dat),
    .inv_req(inv_req), .init_done(init_done),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears one cycle after a read.
  logic [DW-1:0] mem_arr [DP];
  always_ff @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < MW; b++)
          if (ram_wem[b]) mem_arr[ram_addr[4:0]][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem_arr[ram_addr[4:0]];
      end
    end
  end

  // Reference model: expected cache contents and the outstanding fetch.
  logic [DW-1:0] exp_mem [DP];
  logic          pend_vld;
  logic [DW-1:0] pend_dat;

  typedef struct {
    logic          rfl;
    logic          ifu;
    logic [4:0]    addr;
    logic [MW-1:0] wem;
    logic [DW-1:0] dat;
    logic          e_rfl_rdy;
    logic          e_ifu_rdy;
    logic          e_cs;
    logic          e_we;
  } vec_t;
  vec_t tab [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DP; i++) exp_mem[i] = '0;
    pend_vld = 1'b0;
    pend_dat = '0;
  endtask

  // One RUN-state cycle; starts just after a rising edge and ends just after the next.
  task automatic do_cycle(input logic rfl, input logic ifu, input logic [4:0] addr,
                          input logic [MW-1:0] wem, input logic [DW-1:0] dat,
                          output logic o_rfl_rdy, output logic o_ifu_rdy,
                          output logic o_cs, output logic o_we);
    logic          exp_fetch;
    rfl_req_vld  = rfl;
    ifu_req_vld  = ifu;
    rfl_req_addr = {27'd0, addr};
    ifu_req_addr = {27'd0, addr};
    rfl_req_wem  = wem;
    rfl_req_dat  = dat;
    @(negedge clk);
    chk("rsp_vld", {31'd0, ifu_rsp_vld}, {31'd0, pend_vld});
    if (pend_vld) chk("rsp_dat", ifu_rsp_dat, pend_dat);
    chk("rfl_rdy", {31'd0, rfl_req_rdy}, {31'd0, rfl});
    chk("ifu_rdy", {31'd0, ifu_req_rdy}, {31'd0, ~rfl});
    if (rfl || ifu) chk("ram_addr", ram_addr, {27'd0, addr});
    chk("sleep_pins", {29'd0, ram_ls, ram_ds, ram_sd}, 32'd0);
    o_rfl_rdy = rfl_req_rdy;
    o_ifu_rdy = ifu_req_rdy;
    o_cs      = ram_cs;
    o_we      = ram_we;
    exp_fetch = ifu && !rfl;
    pend_vld  = exp_fetch;
    if (exp_fetch) pend_dat = exp_mem[addr];
    if (rfl)
      for (int b = 0; b < MW; b++)
        if (wem[b]) exp_mem[addr][8*b +: 8] = dat[8*b +: 8];
    @(posedge clk); #1;
    rfl_req_vld = 1'b0;
    ifu_req_vld = 1'b0;
  endtask

  initial begin
    logic r_rdy, i_rdy, cs, we;
    int   pat;
    rst_n = 1'b0;
    ifu_req_vld = 0; rfl_req_vld = 0; inv_req = 0;
    ifu_req_addr = '0; rfl_req_addr = '0; rfl_req_wem = '0; rfl_req_dat = '0;
    model_clear();

    tab[0] = '{1'b1, 1'b0, 5'd5, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1};
    tab[1] = '{1'b0, 1'b1, 5'd5, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0};
    tab[2] = '{1'b1, 1'b1, 5'd7, 4'h3, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b1};
    tab[3] = '{1'b0, 1'b1, 5'd7, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0};
    tab[4] = '{1'b0, 1'b0, 5'd0, 4'h0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
    tab[5] = '{1'b1, 1'b0, 5'd7, 4'hC, 32'hAABBCCDD, 1'b1, 1'b0, 1'b1, 1'b1};
    tab[6] = '{1'b0, 1'b1, 5'd7, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0};
    tab[7] = '{1'b0, 1'b1, 5'd0, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0};
    tab[8] = '{1'b0, 1'b1, 5'd5, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_rsp_vld", {31'd0, ifu_rsp_vld}, 32'd0);
    chk("rst_ram_ls", {31'd0, ram_ls}, 32'd0);

    // Sweep after reset, with both requesters pushing throughout.
    rst_n = 1'b1;
    rfl_req_vld = 1'b1;
    ifu_req_vld = 1'b1;
    for (int i = 0; i < DP; i++) begin
      @(negedge clk);
      chk("sweep_addr", ram_addr, i);
      chk("sweep_ctl", {ram_cs, ram_we, ram_wem, rfl_req_rdy, ifu_req_rdy, init_done, ram_din != 0},
          {1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0});
      @(posedge clk); #1;
      if (i == DP - 1) begin rfl_req_vld = 1'b0; ifu_req_vld = 1'b0; end
    end
    @(negedge clk);
    chk("init_done_cyc33", {31'd0, init_done}, 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      do_cycle(tab[i].rfl, tab[i].ifu, tab[i].addr, tab[i].wem, tab[i].dat, r_rdy, i_rdy, cs, we);
      chk($sformatf("tab%0d_hs", i), {28'd0, r_rdy, i_rdy, cs, we},
          {28'd0, tab[i].e_rfl_rdy, tab[i].e_ifu_rdy, tab[i].e_cs, tab[i].e_we});
    end
    do_cycle(0, 0, 5'd0, 4'h0, 32'h0, r_rdy, i_rdy, cs, we);

    for (int n = 0; n < 200; n++) begin
      pat = $urandom_range(1, 3);
      do_cycle(pat[1], pat[0], 5'($urandom_range(0, DP - 1)), 4'($urandom), $urandom,
               r_rdy, i_rdy, cs, we);
    end
    do_cycle(0, 0, 5'd0, 4'h0, 32'h0, r_rdy, i_rdy, cs, we);

    // Invalidate wins over simultaneous requests in RUN.
    inv_req = 1'b1; rfl_req_vld = 1'b1; ifu_req_vld = 1'b1;
    @(negedge clk);
    chk("inv_prio", {29'd0, rfl_req_rdy, ifu_req_rdy, ram_cs}, 32'd0);
    @(posedge clk); #1;
    inv_req = 1'b0; rfl_req_vld = 1'b0; ifu_req_vld = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("inv_sweep_addr", ram_addr, j);
      chk("inv_sweep_done", {31'd0, init_done}, 32'd0);
      @(posedge clk); #1;
    end
    // Invalidate in the middle of the sweep restarts it.
    inv_req = 1'b1;
    @(negedge clk);
    chk("sweep_at20", ram_addr, 32'd20);
    @(posedge clk); #1;
    inv_req = 1'b0;
    for (int j = 0; j < DP; j++) begin
      @(negedge clk);
      chk("restart_addr", ram_addr, j);
      chk("restart_done", {31'd0, init_done}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("restart_init_done", {31'd0, init_done}, 32'd1);
    @(posedge clk); #1;
    model_clear();
    do_cycle(0, 1, 5'd5, 4'h0, 32'h0, r_rdy, i_rdy, cs, we);
    do_cycle(0, 1, 5'd7, 4'h0, 32'h0, r_rdy, i_rdy, cs, we);
    do_cycle(0, 0, 5'd0, 4'h0, 32'h0, r_rdy, i_rdy, cs, we);

    // Reset while a fetch response is outstanding.
    ifu_req_vld = 1'b1; ifu_req_addr = 32'd5;
    @(posedge clk); #1;
    ifu_req_vld = 1'b0;
    chk("pre_rst_rsp", {31'd0, ifu_rsp_vld}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_kills_rsp", {30'd0, ifu_rsp_vld, init_done}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_hold_rsp", {31'd0, ifu_rsp_vld}, 32'd0);
    rst_n = 1'b1;
    for (int j = 0; j < DP; j++) begin
      @(negedge clk);
      chk("rst_sweep_addr", ram_addr, j);
      chk("rst_sweep_ctl", {30'd0, ifu_rsp_vld, ram_cs}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rst_init_done2", {31'd0, init_done}, 32'd1);
    @(posedge clk); #1;
    model_clear();

    do_cycle(1, 0, 5'd3, 4'hF, 32'h0BADF00D, r_rdy, i_rdy, cs, we);
`ifdef N101_ICACHE_RAM_LS_EN
    for (int j = 0; j < 8; j++) do_cycle(0, 0, 5'd0, 4'h0, 32'h0, r_rdy, i_rdy, cs, we);
    @(negedge clk);
    chk("ls_enter", {29'd0, ram_ls, ifu_req_rdy, ram_cs}, 32'd4);
    @(posedge clk); #1;
    ifu_req_vld = 1'b1; ifu_req_addr = 32'd3;
    @(negedge clk);
    chk("ls_req", {29'd0, ram_ls, ifu_req_rdy, ram_cs}, 32'd4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wake", {28'd0, ram_ls, ifu_req_rdy, rfl_req_rdy, ram_cs}, 32'd0);
    @(posedge clk); #1;
    do_cycle(0, 1, 5'd3, 4'h0, 32'h0, r_rdy, i_rdy, cs, we);
    do_cycle(0, 0, 5'd0, 4'h0, 32'h0, r_rdy, i_rdy, cs, we);
`else
    for (int j = 0; j < 12; j++) do_cycle(0, 0, 5'd0, 4'h0, 32'h0, r_rdy, i_rdy, cs, we);
    do_cycle(0, 1, 5'd3, 4'h0, 32'h0, r_rdy, i_rdy, cs, we);
    do_cycle(0, 0, 5'd0, 4'h0, 32'h0, r_rdy, i_rdy, cs, we);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
